alu_sequencer: RTL and testbench

Command-side initiator for the 8-function combinational ALU.
- Accepts operation requests over a valid/ready command port.
- Drives the ALU's opcode, cin, a and b, captures its result and flags, and returns a response over a valid/ready response port.
- Adds a multi-cycle unsigned multiply, built as iterated ALU ADDs with local shifting.
- Sits between the datapath control FSM and the ALU instance. The ALU itself stays outside this block.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu.sv | 45 ++++
 rtl/alu_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the ALU and its command sequencer.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd1;
    localparam logic [2:0] OP_SHL = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    localparam logic [3:0] CMD_MUL = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int FLAG_COUT     = 0;
    localparam int FLAG_ZERO     = 1;
    localparam int FLAG_EQUAL    = 2;
    localparam int FLAG_A_LARGER = 3;

    // Only ADD/SHR/SHL produce a meaningful carry/shift-out.
    function automatic logic is_carry_op(input logic [2:0] op);
        return op <= OP_SHL;
    endfunction

endpackage

// File: rtl/alu.sv
// 8-function combinational ALU driven by alu_sequencer; zero-latency, no flow control.
// Lives beside the sequencer in the enclosing datapath.
module alu
    import alu_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic [2:0]      opcode,
    input  logic            cin,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] c,
    output logic            cout,
    output logic            zero,
    output logic            equal,
    output logic            a_larger
);

    always_comb begin
        c    = '0;
        cout = 1'b0;
        unique case (opcode)
            OP_ADD: {cout, c} = {1'b0, a} + {1'b0, b} + (SIZE+1)'(cin);
            OP_SHR: begin
                c    = {cin, a[SIZE-1:1]};
                cout = a[0];
            end
            OP_SHL: begin
                c    = {a[SIZE-2:0], cin};
                cout = a[SIZE-1];
            end
            OP_NOT: c = ~a;
            OP_AND: c = a & b;
            OP_OR:  c = a | b;
            OP_XOR: c = a ^ b;
            OP_CMP: c = a - b;
            default: c = '0;
        endcase
    end

    assign zero     = (c == '0);
    assign equal    = (a == b);
    assign a_larger = (a > b);

endmodule

// File: rtl/alu_sequencer.sv
// Command-side ALU initiator with iterated-ADD multiply; response 2 / SIZE+1 / 1 edges after accept (op / MUL / illegal).
// One command in flight, cmd_ready only in IDLE; response held stable until rsp_ready.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic              cmd_cin,
    input  logic [SIZE-1:0]   cmd_a,
    input  logic [SIZE-1:0]   cmd_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*SIZE-1:0] rsp_data,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic [2:0]        alu_opcode,
    output logic              alu_cin,
    output logic [SIZE-1:0]   alu_a,
    output logic [SIZE-1:0]   alu_b,
    input  logic [SIZE-1:0]   alu_c,
    input  logic              alu_cout,
    input  logic              alu_equal,
    input  logic              alu_a_larger
);

    localparam int CNT_W = (SIZE > 2) ? $clog2(SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                cin_q, cin_d;
    logic [SIZE-1:0]     a_q, a_d;      // operand A, or the shifting multiplier/low half in MUL
    logic [SIZE-1:0]     b_q, b_d;      // operand B, or the multiplicand in MUL
    logic [SIZE-1:0]     hi_q, hi_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*SIZE-1:0]   data_q, data_d;
    logic [3:0]          flags_q, flags_d;
    logic                err_q, err_d;

    logic [SIZE-1:0]     step_hi;
    logic [SIZE-1:0]     step_lo;

    // One shift-add step: {hi, lo} <= {cout, sum, lo} >> 1.
    assign step_hi = {alu_cout, alu_c[SIZE-1:1]};
    assign step_lo = {alu_c[0], a_q[SIZE-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == CMD_MUL) begin
                        state_d = ST_MUL;
                    end else if (cmd_op[3]) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_MUL: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state_q == ST_IDLE);
        rsp_valid  = (state_q == ST_RESP);
        alu_opcode = OP_ADD;
        alu_cin    = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        unique case (state_q)
            ST_EXEC: begin
                alu_opcode = op_q;
                alu_cin    = cin_q;
                alu_a      = a_q;
                alu_b      = b_q;
            end
            ST_MUL: begin
                alu_opcode = OP_ADD;
                alu_a      = hi_q;
                alu_b      = a_q[0] ? b_q : '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        op_d    = op_q;
        cin_d   = cin_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        flags_d = flags_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d  = cmd_op[2:0];
                    cin_d = cmd_cin;
                    a_d   = cmd_a;
                    b_d   = cmd_b;
                    hi_d  = '0;
                    cnt_d = '0;
                    if (cmd_op[3] && (cmd_op != CMD_MUL)) begin
                        data_d  = '0;
                        flags_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                data_d                   = {{SIZE{1'b0}}, alu_c};
                flags_d                  = '0;
                flags_d[FLAG_ZERO]       = (alu_c == '0);
                flags_d[FLAG_EQUAL]      = alu_equal;
                flags_d[FLAG_A_LARGER]   = alu_a_larger;
                flags_d[FLAG_COUT]       = is_carry_op(op_q) & alu_cout;
                err_d                    = 1'b0;
            end
            ST_MUL: begin
                hi_d  = step_hi;
                a_d   = step_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    data_d             = {step_hi, step_lo};
                    flags_d            = '0;
                    flags_d[FLAG_ZERO] = ({step_hi, step_lo} == '0);
                    err_d              = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            cin_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            op_q    <= op_d;
            cin_q   <= cin_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    assign rsp_data  = data_q;
    assign rsp_flags = flags_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed bench for alu_sequencer paired with the ALU, against a transaction-level model.
`timescale 1ns/1ps
module tb_alu_sequencer;

    localparam int SIZE = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic        cmd_cin = 1'b0;
    logic [7:0]  cmd_a = '0;
    logic [7:0]  cmd_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [2:0]  alu_opcode;
    logic        alu_cin;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_c;
    logic        alu_cout;
    logic        alu_zero;
    logic        alu_equal;
    logic        alu_a_larger;

    always #5 clk = ~clk;

    alu_sequencer #(.SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_cin(cmd_cin),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_opcode(alu_opcode), .alu_cin(alu_cin), .alu_a(alu_a), .alu_b(alu_b),
        .alu_c(alu_c), .alu_cout(alu_cout), .alu_equal(alu_equal), .alu_a_larger(alu_a_larger)
    );

    alu #(.SIZE(SIZE)) u_alu (
        .opcode(alu_opcode), .cin(alu_cin), .a(alu_a), .b(alu_b),
        .c(alu_c), .cout(alu_cout), .zero(alu_zero), .equal(alu_equal), .a_larger(alu_a_larger)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic [3:0]  flags;   // {a_larger, equal, zero, cout}
        logic        err;
        int          lat;
    } rsp_t;

    function automatic rsp_t model(input logic [3:0] op, input logic cin, input logic [7:0] a, input logic [7:0] b);
        rsp_t r;
        int ia, ib, res, cout;
        ia = int'(a);
        ib = int'(b);
        res = 0;
        cout = 0;
        r.err = 1'b0;
        if (op < 8) begin
            case (op)
                0: begin res = (ia + ib + int'(cin)) % 256; cout = (ia + ib + int'(cin)) / 256; end
                1: begin res = ia / 2 + (cin ? 128 : 0); cout = ia % 2; end
                2: begin res = (ia * 2 + int'(cin)) % 256; cout = ia / 128; end
                3: res = 255 - ia;
                4: res = int'(a & b);
                5: res = int'(a | b);
                6: res = int'(a ^ b);
                default: res = (ia - ib + 256) % 256;
            endcase
            r.data  = 16'(res);
            r.flags = {ia > ib, ia == ib, res == 0, cout != 0};
            r.lat   = 2;
        end else if (op == 8) begin
            r.data  = 16'(ia * ib);
            r.flags = {1'b0, 1'b0, (ia * ib) == 0, 1'b0};
            r.lat   = SIZE + 1;
        end else begin
            r.data  = '0;
            r.flags = '0;
            r.err   = 1'b1;
            r.lat   = 1;
        end
        return r;
    endfunction

    // Reference timeline: one command in flight, accepted only when idle.
    bit         busy = 1'b0;
    int         since = 0;
    rsp_t       m_exp;
    logic [3:0] m_op;
    logic [7:0] m_a, m_b;
    logic       m_cin;
    bit         mon_rv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 1'b0;
        end else if (!busy) begin
            if (cmd_valid) begin
                busy  = 1'b1;
                since = 1;
                m_op  = cmd_op;
                m_cin = cmd_cin;
                m_a   = cmd_a;
                m_b   = cmd_b;
                m_exp = model(cmd_op, cmd_cin, cmd_a, cmd_b);
            end
        end else if (since >= m_exp.lat && rsp_ready) begin
            busy = 1'b0;
        end else begin
            since++;
        end
    end

    always @(negedge clk) begin
        mon_rv = busy && (since >= m_exp.lat);
        chk("cmd_ready", cmd_ready, !busy);
        chk("rsp_valid", rsp_valid, mon_rv);
        if (mon_rv) begin
            chk("rsp_data", rsp_data, m_exp.data);
            chk("rsp_flags", rsp_flags, m_exp.flags);
            chk("rsp_err", rsp_err, m_exp.err);
        end else if (busy && m_op == 4'd8) begin
            chk("mul_opcode", {alu_opcode, alu_cin}, 4'b0000);
            chk("mul_b", (alu_b == 8'h00) || (alu_b == m_b), 1);
        end else if (busy && m_op < 4'd8) begin
            chk("exec_drive", {alu_opcode, alu_cin, alu_a, alu_b}, {m_op[2:0], m_cin, m_a, m_b});
        end else begin
            chk("alu_idle", {alu_opcode, alu_cin, alu_a, alu_b}, 0);
        end
    end

    task automatic send(input logic [3:0] op, input logic cin, input logic [7:0] a, input logic [7:0] b,
                        input int stall, output logic [15:0] d, output logic [3:0] f,
                        output logic e, output int lat);
        int guard;
        d = '0; f = '0; e = 1'b0; lat = -1;
        cmd_op = op; cmd_cin = cin; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept: cmd_ready stayed 0, required 1");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) begin
            n_checks++; n_fail++;
            $display("FAIL response: rsp_valid stayed 0, required 1");
            return;
        end
        repeat (stall) begin
            @(posedge clk); #1;
        end
        d = rsp_data; f = rsp_flags; e = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [3:0]  f;
        logic        e;
        int          lat, guard;
        rsp_t        r;
        logic [3:0]  op;
        logic [7:0]  ra, rb;
        logic        rc;

        #1;
        chk("reset_ready_valid", {cmd_ready, rsp_valid}, 2'b10);
        chk("reset_rsp", {rsp_data, rsp_flags, rsp_err}, 0);
        chk("reset_alu", {alu_opcode, alu_cin, alu_a, alu_b}, 0);
        #22 rst_n = 1'b1;
        @(posedge clk); #1;

        send(4'd0, 1'b0, 8'hF0, 8'h20, 0, d, f, e, lat);
        chk("t1_data", d, 16'h0010);
        chk("t1_flags", f, 4'b1001);
        chk("t1_lat", lat, 2);

        send(4'd6, 1'b0, 8'h5A, 8'h5A, 1, d, f, e, lat);
        chk("t2_xor_data", d, 16'h0000);
        chk("t2_xor_flags", f, 4'b0110);
        send(4'd2, 1'b1, 8'h81, 8'h00, 0, d, f, e, lat);
        chk("t2_shl_data", d, 16'h0003);
        chk("t2_shl_flags", f, 4'b1001);

        send(4'd8, 1'b0, 8'hFF, 8'hFF, 0, d, f, e, lat);
        chk("t3_mul_data", d, 16'hFE01);
        chk("t3_mul_flags", f, 4'b0000);
        chk("t3_mul_lat", lat, 9);
        send(4'd8, 1'b0, 8'h00, 8'h55, 0, d, f, e, lat);
        chk("t3_mul0_data", d, 16'h0000);
        chk("t3_mul0_flags", f, 4'b0010);

        // Backpressure with a second command already offered while busy.
        cmd_op = 4'd0; cmd_cin = 1'b0; cmd_a = 8'h01; cmd_b = 8'h01; cmd_valid = 1'b1;
        @(negedge clk);
        chk("t4_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_a = 8'h02; cmd_b = 8'h03;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t4_lat", lat, 2);
        repeat (5) begin
            chk("t4_data_stable", rsp_data, 16'h0002);
            chk("t4_busy", cmd_ready, 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("t4_ready_after_hs", {cmd_ready, rsp_valid}, 2'b10);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("t4_second_accepted", cmd_ready, 0);
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("t4_second_data", rsp_data, 16'h0005);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        send(4'hB, 1'b0, 8'h12, 8'h34, 0, d, f, e, lat);
        chk("t5_illegal", {d, f, e}, {16'h0000, 4'h0, 1'b1});
        chk("t5_lat", lat, 1);
        send(4'd0, 1'b0, 8'h03, 8'h04, 0, d, f, e, lat);
        chk("t5_legal_err", e, 0);
        chk("t5_legal_data", d, 16'h0007);

        // Asynchronous reset in the middle of a multiply.
        cmd_op = 4'd8; cmd_cin = 1'b0; cmd_a = 8'h07; cmd_b = 8'h09; cmd_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_ready_valid", {cmd_ready, rsp_valid}, 2'b10);
        chk("t6_rsp", {rsp_data, rsp_flags, rsp_err}, 0);
        chk("t6_alu", {alu_opcode, alu_cin, alu_a, alu_b}, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_no_rsp", rsp_valid, 0);
        send(4'd8, 1'b0, 8'h03, 8'h05, 0, d, f, e, lat);
        chk("t6_mul_data", d, 16'h000F);

        for (int i = 0; i < 80; i++) begin
            int k;
            k = int'($urandom_range(0, 9));
            if (k < 6)      op = 4'($urandom_range(0, 7));
            else if (k < 8) op = 4'd8;
            else            op = 4'($urandom_range(9, 15));
            ra = 8'($urandom);
            rb = (k == 5) ? ra : 8'($urandom);
            rc = 1'($urandom);
            r  = model(op, rc, ra, rb);
            send(op, rc, ra, rb, int'($urandom_range(0, 3)), d, f, e, lat);
            chk("rnd_result", {d, f, e}, {r.data, r.flags, r.err});
            chk("rnd_lat", lat, r.lat);
            repeat (int'($urandom_range(0, 2))) begin
                @(posedge clk); #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
